// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for CPU, renderer and OAM-DMA: one registered command per cycle, acks one cycle later.
// Build option VRAM_ARB_DMA_EN: enables the DMA port and the CPU starvation guard; otherwise DMA is inert.
module vram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_ena,
  input  logic [1:0]  phase,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ren_req,
  input  logic [12:0] ren_addr,
  output logic        ren_ack,
  output logic [7:0]  ren_rdata,
  input  logic        dma_req,
  input  logic [12:0] dma_addr,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  localparam logic [1:0] PH_DRAW = 2'd3;

  logic draw;
  logic cpu_tag, cpu_tag_lock, cpu_tag_we, ren_tag;
  logic cpu_elig, ren_elig, dma_elig, cpu_boost;
  logic grant_cpu, grant_lock, grant_ren, grant_dma;

  assign draw     = lcd_ena && (phase == PH_DRAW);
  assign cpu_elig = cpu_req && !(cpu_tag || cpu_tag_lock);
  assign ren_elig = ren_req && !ren_tag;

`ifdef VRAM_ARB_DMA_EN
  logic       dma_tag;
  logic [1:0] starve_cnt;

  assign dma_elig  = dma_req && !dma_tag;
  assign cpu_boost = (starve_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_tag    <= 1'b0;
      starve_cnt <= 2'd0;
    end else begin
      dma_tag <= grant_dma;
      if (!cpu_req || grant_cpu || grant_lock)
        starve_cnt <= 2'd0;
      else if (cpu_elig && grant_dma && !draw && (starve_cnt != 2'd3))
        starve_cnt <= starve_cnt + 2'd1;
    end
  end

  assign dma_ack   = dma_tag;
  assign dma_rdata = dma_tag ? mem_rdata : 8'h00;
`else
  logic dma_unused;

  assign dma_unused = dma_req;
  assign dma_elig   = 1'b0;
  assign cpu_boost  = 1'b0;
  assign dma_ack    = 1'b0;
  assign dma_rdata  = 8'h00;
`endif

  // During DRAW the CPU never touches VRAM; its lockout ack runs beside the VRAM winner.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_lock = 1'b0;
    grant_ren  = 1'b0;
    grant_dma  = 1'b0;
    if (draw) begin
      grant_lock = cpu_elig;
      if (ren_elig)
        grant_ren = 1'b1;
      else if (dma_elig)
        grant_dma = 1'b1;
    end else if (cpu_elig && (!dma_elig || cpu_boost)) begin
      grant_cpu = 1'b1;
    end else if (dma_elig) begin
      grant_dma = 1'b1;
    end else if (ren_elig) begin
      grant_ren = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_tag      <= 1'b0;
      cpu_tag_lock <= 1'b0;
      cpu_tag_we   <= 1'b0;
      ren_tag      <= 1'b0;
      mem_addr     <= 13'h0000;
      mem_we       <= 1'b0;
      mem_wdata    <= 8'h00;
    end else begin
      cpu_tag      <= grant_cpu;
      cpu_tag_lock <= grant_lock;
      cpu_tag_we   <= cpu_we && (grant_cpu || grant_lock);
      ren_tag      <= grant_ren;
      mem_we       <= grant_cpu && cpu_we;
      if (grant_cpu) begin
        mem_addr <= cpu_addr;
        if (cpu_we)
          mem_wdata <= cpu_wdata;
      end else if (grant_ren) begin
        mem_addr <= ren_addr;
      end else if (grant_dma) begin
        mem_addr <= dma_addr;
      end
    end
  end

  assign cpu_ack   = cpu_tag || cpu_tag_lock;
  assign cpu_rdata = cpu_tag_we   ? 8'h00     :
                     cpu_tag      ? mem_rdata :
                     cpu_tag_lock ? 8'hFF     : 8'h00;
  assign ren_ack   = ren_tag;
  assign ren_rdata = ren_tag ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected outputs queued as stimulus is applied, compared after each edge.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_ena;
  logic [1:0]  phase;
  logic [1:0]  ph_next;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ren_req;
  logic [12:0] ren_addr;
  logic        ren_ack;
  logic [7:0]  ren_rdata;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0] vram [0:8191];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        cpu_ack;
    logic [7:0]  cpu_rd;
    logic        ren_ack;
    logic [7:0]  ren_rd;
    logic        dma_ack;
    logic [7:0]  dma_rd;
    logic        mem_we;
    logic        addr_v;
    logic [12:0] addr;
  } exp_t;

  exp_t sb[$];

  vram_arbiter dut (
    .clk(clk), .rst(rst), .lcd_ena(lcd_ena), .phase(phase),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_ack(ren_ack), .ren_rdata(ren_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural VRAM: combinational read of the registered address, write at the edge.
  assign mem_rdata = vram[mem_addr];
  always @(posedge clk) if (mem_we) vram[mem_addr] <= mem_wdata;

  function automatic logic [7:0] pat(input logic [12:0] a);
    logic [12:0] t;
    t = a;
    return t[7:0] ^ {3'b000, t[12:8]} ^ 8'h5A;
  endfunction

  function automatic exp_t mk(input logic ca, input logic [7:0] cd,
                              input logic ra, input logic [7:0] rd,
                              input logic da, input logic [7:0] dd,
                              input logic we, input logic av, input logic [12:0] ad);
    exp_t e;
    e.name = "";
    e.cpu_ack = ca; e.cpu_rd = cd;
    e.ren_ack = ra; e.ren_rd = rd;
    e.dma_ack = da; e.dma_rd = dd;
    e.mem_we = we; e.addr_v = av; e.addr = ad;
    return e;
  endfunction

  task automatic chk_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick(input string name, input exp_t e);
    exp_t x;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 phase = ph_next;
    #2;
    x = sb.pop_front();
    chk_val({x.name, ".cpu_ack"},   16'(cpu_ack),   16'(x.cpu_ack));
    chk_val({x.name, ".cpu_rdata"}, 16'(cpu_rdata), 16'(x.cpu_rd));
    chk_val({x.name, ".ren_ack"},   16'(ren_ack),   16'(x.ren_ack));
    chk_val({x.name, ".ren_rdata"}, 16'(ren_rdata), 16'(x.ren_rd));
    chk_val({x.name, ".dma_ack"},   16'(dma_ack),   16'(x.dma_ack));
    chk_val({x.name, ".dma_rdata"}, 16'(dma_rdata), 16'(x.dma_rd));
    chk_val({x.name, ".mem_we"},    16'(mem_we),    16'(x.mem_we));
    if (x.addr_v)
      chk_val({x.name, ".mem_addr"}, 16'(mem_addr), 16'(x.addr));
  endtask

  task automatic set_ph(input logic l, input logic [1:0] p);
    lcd_ena = l;
    phase   = p;
    ph_next = p;
  endtask

  task automatic cpu_drive(input logic r, input logic w, input logic [12:0] a, input logic [7:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = pat(13'(i));

    rst = 1'b1;
    set_ph(1'b0, 2'd0);
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    ren_req = 1'b0; ren_addr = 13'h0;
    dma_req = 1'b0; dma_addr = 13'h0;
    tick("reset", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0000));
    rst = 1'b0;
    tick("post_reset", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0000));

    // Preload 0x1800 with a known value, then write/read-back at 0x0010 in HBLANK.
    set_ph(1'b1, 2'd0);
    cpu_drive(1'b1, 1'b1, 13'h1800, 8'h3C);
    tick("pre_wr", mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 13'h1800));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("pre_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h1800));
    cpu_drive(1'b1, 1'b1, 13'h0010, 8'hA5);
    tick("hb_wr", mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 13'h0010));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("hb_wr_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b1, 1'b0, 13'h0010, 8'h00);
    tick("hb_rd", mk(1, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("hb_rd_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));

    // DRAW lockout: read returns FF, write dropped, mem_addr untouched.
    set_ph(1'b1, 2'd3);
    cpu_drive(1'b1, 1'b0, 13'h1800, 8'h00);
    tick("draw_rd", mk(1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("draw_rd_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b1, 1'b1, 13'h1800, 8'h77);
    tick("draw_wr", mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("draw_wr_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    set_ph(1'b1, 2'd0);
    cpu_drive(1'b1, 1'b0, 13'h1800, 8'h00);
    tick("hb_rd_old", mk(1, 8'h3C, 0, 8'h00, 0, 8'h00, 0, 1, 13'h1800));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("hb_rd_old_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h1800));

    // LCD off: DRAW phase does not lock the CPU out.
    set_ph(1'b0, 2'd3);
    cpu_drive(1'b1, 1'b0, 13'h0010, 8'h00);
    tick("lcd_off_rd", mk(1, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("lcd_off_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0010));

    // HBLANK: CPU beats renderer, renderer follows next cycle.
    set_ph(1'b1, 2'd0);
    cpu_drive(1'b1, 1'b0, 13'h0456, 8'h00);
    ren_req = 1'b1; ren_addr = 13'h0789;
    tick("hb_cpu_first", mk(1, pat(13'h0456), 0, 8'h00, 0, 8'h00, 0, 1, 13'h0456));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("hb_ren_second", mk(0, 8'h00, 1, pat(13'h0789), 0, 8'h00, 0, 1, 13'h0789));
    ren_req = 1'b0;
    tick("hb_ren_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0789));

    // DRAW: renderer and DMA requesting continuously alternate.
    set_ph(1'b1, 2'd3);
    ren_req = 1'b1; ren_addr = 13'h0123;
    dma_req = 1'b1; dma_addr = 13'h0245;
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 1)
        tick($sformatf("draw_alt%0d", k), mk(0, 8'h00, 1, pat(13'h0123), 0, 8'h00, 0, 1, 13'h0123));
      else begin
`ifdef VRAM_ARB_DMA_EN
        tick($sformatf("draw_alt%0d", k), mk(0, 8'h00, 0, 8'h00, 1, pat(13'h0245), 0, 1, 13'h0245));
`else
        tick($sformatf("draw_alt%0d", k), mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0123));
`endif
      end
    end
    ren_req = 1'b0; dma_req = 1'b0;
    tick("draw_alt_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 13'h0));

    // VBLANK: CPU and DMA requesting continuously.
    set_ph(1'b1, 2'd1);
    cpu_drive(1'b1, 1'b0, 13'h0300, 8'h00);
    dma_req = 1'b1; dma_addr = 13'h0245;
    for (int k = 1; k <= 4; k++) begin
`ifdef VRAM_ARB_DMA_EN
      if (k % 2 == 1)
        tick($sformatf("vb_mix%0d", k), mk(0, 8'h00, 0, 8'h00, 1, pat(13'h0245), 0, 1, 13'h0245));
      else
        tick($sformatf("vb_mix%0d", k), mk(1, pat(13'h0300), 0, 8'h00, 0, 8'h00, 0, 1, 13'h0300));
`else
      if (k % 2 == 1)
        tick($sformatf("vb_mix%0d", k), mk(1, pat(13'h0300), 0, 8'h00, 0, 8'h00, 0, 1, 13'h0300));
      else
        tick($sformatf("vb_mix%0d", k), mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0300));
`endif
    end
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    dma_req = 1'b0;
    tick("vb_mix_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 13'h0));

    // CPU read granted in the last HBLANK cycle; phase moves to DRAW before the ack.
    set_ph(1'b1, 2'd0);
    cpu_drive(1'b1, 1'b0, 13'h0400, 8'h00);
    ph_next = 2'd3;
    tick("hb_to_draw", mk(1, pat(13'h0400), 0, 8'h00, 0, 8'h00, 0, 1, 13'h0400));
    cpu_drive(1'b0, 1'b0, 13'h0, 8'h00);
    tick("hb_to_draw_idle", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0400));

    // Reset in the cycle a renderer grant issues: no ack, outputs cleared.
    set_ph(1'b1, 2'd0);
    ren_req = 1'b1; ren_addr = 13'h0555;
    rst = 1'b1;
    tick("rst_grant", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0000));
    rst = 1'b0;
    ren_req = 1'b0;
    tick("rst_after", mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 13'h0000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 lcd_ena  in  1  LCDC.ena; 0 = renderer idle, CPU unrestricted.
REQ-004 phase  in  2  PPU phase: 0 HBLANK, 1 VBLANK, 2 OAM_SCAN, 3 DRAW.
REQ-005 cpu_req / cpu_we  in  1/1  CPU request / write strobe; held until cpu_ack.
REQ-006 cpu_addr / cpu_wdata  in  13/8  CPU VRAM offset / write data.
REQ-007 cpu_ack / cpu_rdata  out  1/8  one-cycle completion pulse / read data, valid with ack.
REQ-008 ren_req / ren_addr  in  1/13  renderer fetch request (read-only), held until ren_ack.
REQ-009 ren_ack / ren_rdata  out  1/8  renderer completion pulse / data.
REQ-010 dma_req / dma_addr  in  1/13  OAM-DMA source read (read-only), held until dma_ack.
REQ-011 dma_ack / dma_rdata  out  1/8  DMA completion pulse / data.
REQ-012 mem_addr / mem_we / mem_wdata  out  13/1/8  single-port VRAM command, registered.
REQ-013 mem_rdata  in  8  VRAM read data, valid one cycle after command.

Function
REQ-014 One VRAM command issued per cycle max; winner chosen combinationally from requests, command registered onto mem_* at posedge.
REQ-015 Request granted at cycle N -> matching ack pulses at N+1 with rdata = mem_rdata (writes: rdata = 0); latency exactly 1 cycle.
REQ-016 Requester with outstanding grant (granted previous cycle) excluded from arbitration; per-requester throughput one access per 2 cycles.
REQ-017 Priority, lcd_ena=1 and phase=DRAW: renderer > DMA; CPU locked out.
REQ-018 Locked-out CPU read: acked next cycle with cpu_rdata = 8'hFF, no VRAM command; locked-out write: acked next cycle, dropped, mem_we stays 0.
REQ-019 Priority, other phases or lcd_ena=0: DMA > CPU > renderer.
REQ-020 Starvation guard: 2-bit counter increments each cycle CPU eligible but loses to DMA; at 3, CPU beats DMA next cycle; counter clears on CPU grant or cpu_req=0.
REQ-021 Lockout decision taken at grant cycle; phase change between grant and ack does not alter response.
REQ-022 No requests eligible -> mem_we=0, mem_addr holds previous value, no ack.
REQ-023 Acks mutually exclusive except CPU lockout ack, which may coincide with renderer/DMA ack.
REQ-024 mem_we asserted only for a granted CPU write.

Reset
REQ-025 rst at any posedge: all acks 0, all rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, starvation counter 0, outstanding tag cleared.
REQ-026 Transaction granted in the cycle rst asserts is discarded; no ack after reset.

Configuration
REQ-027 Macro VRAM_ARB_DMA_EN defined: DMA port and starvation guard (REQ-020) present as specified.
REQ-028 VRAM_ARB_DMA_EN undefined: dma_* ports still exist; dma_req ignored, dma_ack and dma_rdata tied 0, starvation counter removed; priority CPU > renderer outside DRAW.

Verification
REQ-029 HBLANK, cpu write addr 13'h0010 data 8'hA5, then read same addr -> mem_we=1 once, read ack with cpu_rdata=8'hA5 one cycle after grant.
REQ-030 DRAW, cpu read addr 13'h1800 -> cpu_ack next cycle, cpu_rdata=8'hFF, no VRAM command; cpu write during DRAW -> mem_we never 1, later HBLANK read returns old data.
REQ-031 DRAW, ren_req and dma_req continuously -> ren granted first, DMA takes alternate cycles (ren ack cycles 1,3,5; dma 2,4,6).
REQ-032 VBLANK, dma_req and cpu_req continuously (macro defined) -> CPU granted no later than 4th cycle; macro undefined -> dma_ack never pulses.
REQ-033 CPU read granted last HBLANK cycle, phase->DRAW next cycle -> ack carries real VRAM data, not 8'hFF.
REQ-034 rst asserted the cycle a renderer grant issues -> no ren_ack, all outputs 0 next cycle.
